led_cmd_gen: RTL and testbench

LED_CMD_GEN -- requirements
Module: led_cmd_gen

---
 rtl/led_cmd_gen_pkg.sv | 10 +
 rtl/led_cmd_gen_btn_debounce.sv | 42 ++++
 rtl/led_cmd_gen.sv | 84 ++++++++
 tb/tb_led_cmd_gen.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/led_cmd_gen_pkg.sv
// Shared constants and FSM encoding for the LED command generator.
package led_cmd_gen_pkg;
   localparam int unsigned NUM_LEDS         = 3;
   localparam int unsigned DEFAULT_CLK_FREQ = 50_000_000;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;
endpackage

// File: rtl/led_cmd_gen_btn_debounce.sv
// One button: two-flop synchronizer, stable-sample debounce, rising-edge press pulse.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic press
);
   localparam int unsigned CYC   = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
   localparam int unsigned CNT_W = (CYC < 2) ? 1 : $clog2(CYC);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYC - 1);

   logic             sync1;
   logic             sync2;
   logic             level;
   logic [CNT_W-1:0] cnt;

   // cnt holds how many consecutive samples have disagreed with the accepted level
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         level <= 1'b0;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         press <= 1'b0;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            level <= sync2;
            cnt   <= '0;
            press <= sync2;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end
endmodule

// File: rtl/led_cmd_gen.sv
// Toggles one LED command bit per debounced button press; clears all LEDs after a hold timeout.
module led_cmd_gen
   import led_cmd_gen_pkg::*;
#(
   parameter int unsigned CLK_FREQ    = DEFAULT_CLK_FREQ,
   parameter int unsigned DEBOUNCE_MS = 20,
   parameter int unsigned HOLD_TIME   = 30
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_LEDS-1:0] btn,
   output logic [NUM_LEDS-1:0] cmd,
   output logic                cmd_valid,
   output logic                active
);
   localparam int unsigned DEBOUNCE_CYCLES = CLK_FREQ / 1000 * DEBOUNCE_MS;
   localparam logic [31:0] HOLD_CYCLES     = 32'(CLK_FREQ * HOLD_TIME);
   localparam logic [31:0] TIMER_LAST      = HOLD_CYCLES - 32'd1;

   logic [NUM_LEDS-1:0] press;
   logic [NUM_LEDS-1:0] cmd_next;
   state_t              state;
   logic [31:0]         timer;

   for (genvar i = 0; i < NUM_LEDS; i++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk   (clk),
         .reset (reset),
         .btn   (btn[i]),
         .press (press[i])
      );
   end

   assign cmd_next = cmd ^ press;

   // A press always wins over a coinciding timeout; any press changes cmd, so it always pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         cmd       <= '0;
         cmd_valid <= 1'b0;
         active    <= 1'b0;
         state     <= IDLE;
         timer     <= '0;
      end else begin
         cmd_valid <= 1'b0;
         if (press != '0) begin
            cmd       <= cmd_next;
            cmd_valid <= 1'b1;
            timer     <= '0;
            if (cmd_next != '0) begin
               state  <= ACTIVE;
               active <= 1'b1;
            end else begin
               state  <= IDLE;
               active <= 1'b0;
            end
         end else begin
            case (state)
               IDLE: begin
                  timer <= '0;
               end
               ACTIVE: begin
                  if (timer >= TIMER_LAST) begin
                     cmd       <= '0;
                     cmd_valid <= 1'b1;
                     timer     <= '0;
                     state     <= IDLE;
                     active    <= 1'b0;
                  end else begin
                     timer <= timer + 32'd1;
                  end
               end
               default: begin
                  state  <= IDLE;
                  active <= 1'b0;
                  timer  <= '0;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_led_cmd_gen.sv
// Directed and random bench for led_cmd_gen with a sample-history reference model.
module tb_led_cmd_gen;
   localparam int D    = 4;
   localparam int HOLD = 1000;

   logic       clk;
   logic       reset;
   logic [2:0] btn;
   logic [2:0] cmd;
   logic       cmd_valid;
   logic       active;

   int errors = 0;
   int checks = 0;
   int n;

   // Reference state: raw input history, accepted levels, pending presses, expected outputs.
   logic [2:0] raw_q[$];
   logic [2:0] lvl_m;
   logic [2:0] pend_m;
   logic [2:0] cmd_m;
   logic       valid_m;
   int         cyc;
   int         last_ev;

   led_cmd_gen #(
      .CLK_FREQ    (1000),
      .DEBOUNCE_MS (4),
      .HOLD_TIME   (1)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .btn       (btn),
      .cmd       (cmd),
      .cmd_valid (cmd_valid),
      .active    (active)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      raw_q.delete();
      repeat (D + 2) raw_q.push_back(3'b000);
      lvl_m   = '0;
      pend_m  = '0;
      cmd_m   = '0;
      valid_m = 1'b0;
      last_ev = cyc;
   endtask

   task automatic tick();
      logic [2:0] in_b;
      logic       rst_b;
      logic       all_diff;
      @(posedge clk);
      in_b  = btn;
      rst_b = reset;
      cyc++;
      if (rst_b) begin
         model_reset();
      end else begin
         valid_m = 1'b0;
         if (pend_m != 3'b000) begin
            cmd_m   = cmd_m ^ pend_m;
            valid_m = 1'b1;
            last_ev = cyc;
         end else if (cmd_m != 3'b000 && (cyc - last_ev) == HOLD) begin
            cmd_m   = 3'b000;
            valid_m = 1'b1;
         end
         raw_q.push_back(in_b);
         pend_m = 3'b000;
         // input seen by the debouncer at this edge arrived two edges earlier
         for (int b = 0; b < 3; b++) begin
            all_diff = 1'b1;
            for (int j = 0; j < D; j++) begin
               if (raw_q[raw_q.size() - 3 - j][b] == lvl_m[b]) all_diff = 1'b0;
            end
            if (all_diff) begin
               lvl_m[b] = ~lvl_m[b];
               if (lvl_m[b]) pend_m[b] = 1'b1;
            end
         end
         while (raw_q.size() > D + 3) void'(raw_q.pop_front());
      end
      #1;
      chk("model_cmd", 32'(cmd), 32'(cmd_m));
      chk("model_cmd_valid", 32'(cmd_valid), 32'(valid_m));
      chk("model_active", 32'(active), 32'(cmd_m != 3'b000));
   endtask

   task automatic wait_valid(input int max_cycles, output int cnt);
      cnt = 0;
      while (cnt < max_cycles) begin
         tick();
         cnt++;
         if (cmd_valid === 1'b1) break;
      end
   endtask

   initial begin
      clk   = 1'b0;
      reset = 1'b1;
      btn   = 3'b000;
      cyc   = 0;
      model_reset();

      repeat (3) tick();
      chk("reset_cmd", 32'(cmd), 32'd0);
      chk("reset_valid", 32'(cmd_valid), 32'd0);
      chk("reset_active", 32'(active), 32'd0);
      reset = 1'b0;
      tick();

      // Clean single press, then a second press toggles it back off
      btn = 3'b001;
      wait_valid(20, n);
      chk("press_latency", 32'(n), 32'd7);
      chk("press_cmd", 32'(cmd), 32'b001);
      chk("press_active", 32'(active), 32'd1);
      repeat (3) tick();
      btn = 3'b000;
      repeat (10) tick();
      btn = 3'b001;
      wait_valid(20, n);
      chk("toggle_off_cmd", 32'(cmd), 32'b000);
      chk("toggle_off_active", 32'(active), 32'd0);
      repeat (3) tick();
      btn = 3'b000;
      repeat (10) tick();

      // Bouncing button yields a single toggle
      btn = 3'b010; tick();
      btn = 3'b000; tick();
      btn = 3'b010; tick();
      btn = 3'b000; tick();
      btn = 3'b010;
      wait_valid(20, n);
      chk("bounce_latency", 32'(n), 32'd7);
      chk("bounce_cmd", 32'(cmd), 32'b010);
      btn = 3'b000;

      // Idle hold expires
      wait_valid(1200, n);
      chk("timeout_latency", 32'(n), 32'd1000);
      chk("timeout_cmd", 32'(cmd), 32'b000);
      chk("timeout_active", 32'(active), 32'd0);
      repeat (5) tick();

      // Simultaneous presses land in one cycle
      btn = 3'b101;
      wait_valid(20, n);
      chk("simul_latency", 32'(n), 32'd7);
      chk("simul_cmd", 32'(cmd), 32'b101);
      tick();
      chk("simul_single_pulse", 32'(cmd_valid), 32'd0);
      btn = 3'b000;

      // Press arrives exactly on the timeout cycle
      repeat (992) tick();
      btn = 3'b010;
      wait_valid(20, n);
      chk("collide_latency", 32'(n), 32'd7);
      chk("collide_cmd", 32'(cmd), 32'b111);
      chk("collide_active", 32'(active), 32'd1);
      btn = 3'b000;
      wait_valid(1200, n);
      chk("collide_timeout_latency", 32'(n), 32'd1000);
      chk("collide_timeout_cmd", 32'(cmd), 32'b000);
      repeat (5) tick();

      // Reset in the middle of a debounce with LEDs on
      btn = 3'b011;
      wait_valid(20, n);
      chk("pre_reset_cmd", 32'(cmd), 32'b011);
      btn = 3'b000;
      repeat (10) tick();
      btn = 3'b100;
      repeat (3) tick();
      reset = 1'b1;
      tick();
      chk("midreset_cmd", 32'(cmd), 32'd0);
      chk("midreset_active", 32'(active), 32'd0);
      chk("midreset_valid", 32'(cmd_valid), 32'd0);
      reset = 1'b0;
      wait_valid(20, n);
      chk("held_through_reset_latency", 32'(n), 32'd7);
      chk("held_through_reset_cmd", 32'(cmd), 32'b100);
      btn = 3'b000;
      repeat (10) tick();

      // Random buttons with occasional resets
      for (int it = 0; it < 60; it++) begin
         reset = ($urandom_range(0, 24) == 0);
         btn   = 3'($urandom_range(0, 7));
         repeat ($urandom_range(1, 12)) tick();
      end
      reset = 1'b0;
      btn   = 3'b000;
      repeat (1100) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
